panel_key_sequencer: RTL and testbench
======================================

# panel_key_sequencer

Front-panel key sequencer between the panel scanner's debounced switch outputs and the CPU's manual-control logic. It turns the six momentary keys (START, LOAD ADD, DEP, EXAM, CONT, STOP) into single, arbitrated, interlocked key requests with a valid/ack handshake. It enforces release-before-repress and registers the SING STEP / SING INST toggle levels. It sits in the top level between the panel driver and the CPU control unit.

## Interface
Parameters:
- HOLD_CYCLES, 100000 — consecutive cycles with all momentary keys low required before a new key is accepted (1 ms at 100 MHz); range 1..2^24-1.
- ACK_TIMEOUT, 0 — cycles to wait for key_ack before abandoning a request; 0 disables the timeout; range 0..2^24-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start, load_addr, dep, exam, cont, stop  in  1 each  debounced momentary key levels, 1 = pressed.
- sing_step, sing_inst  in  1 each  debounced toggle switch levels.
- run  in  1  CPU run flip-flop.
- key_ack  in  1  CPU has consumed the current request.
- key_valid  out  1  request pending.
- key_code  out  3  0=START, 1=LOAD ADD, 2=DEP, 3=EXAM, 4=CONT, 5=STOP; 6 and 7 are never driven.
- key_reject  out  1  one-cycle pulse when a press is discarded by interlock.
- ack_timeout  out  1  sticky flag: a request was abandoned.
- sing_step_mode, sing_inst_mode  out  1 each  registered toggle levels.

## Operation
- Each key has a prev register. A press is current=1 and prev=1'b0. prev updates every cycle, including during rst, when it loads the current input level.
- Arbitration: if several presses occur in the same cycle, priority is STOP > START > LOAD ADD > DEP > EXAM > CONT. Lower-priority presses in that cycle are dropped silently, with no key_reject.
- Interlock, applied to the winning press using run in the same cycle:
  - run=1: only STOP is accepted.
  - run=0: STOP is rejected; all other keys are accepted.
  - A rejected press pulses key_reject and moves the FSM to WAIT_RELEASE.
- FSM states: IDLE, ISSUE, WAIT_RELEASE.
  - IDLE: on an accepted press, register key_code, set key_valid=1, clear the timer, and go to ISSUE.
  - ISSUE: key_valid and key_code are held stable. When key_ack=1 is sampled, key_valid goes to 0 at that edge and the FSM goes to WAIT_RELEASE. If ACK_TIMEOUT≠0 and the timer reaches ACK_TIMEOUT, key_valid goes to 0, ack_timeout is set to 1, and the FSM goes to WAIT_RELEASE. A run change during ISSUE does not cancel the request.
  - WAIT_RELEASE: the timer clears in any cycle where any momentary key is high and increments otherwise. When the timer reaches HOLD_CYCLES, the FSM goes to IDLE. Presses seen in this state are ignored.
- key_ack is ignored outside ISSUE.
- The timer is 24 bits and saturates; it never wraps.
- sing_step_mode <= sing_step and sing_inst_mode <= sing_inst every cycle. Both may be 1 at once; they are passed through without interpretation.

## Timing
- Reset values: key_valid=0, key_code=0, key_reject=0, ack_timeout=0, sing_step_mode=0, sing_inst_mode=0; state=IDLE.
- A key held through reset never produces a request, because prev equals 1 when rst deasserts.
- Press latency: a key input first sampled high at edge k (low at k-1) gives key_valid=1 or key_reject=1 after edge k.
- key_reject lasts exactly one cycle.
- Ack: key_ack high at edge m gives key_valid=0 after edge m. key_ack may already be high in the first ISSUE cycle; the minimum request length is one cycle.
- Timeout: key_valid lasts exactly ACK_TIMEOUT cycles when no ack arrives.
- Minimum repress spacing: the key must be low for HOLD_CYCLES cycles after the ack (or after the reject). The earliest acceptable press is on the edge after IDLE is re-entered.
- Toggle outputs have one-cycle latency.

## Test plan
- HOLD_CYCLES=8, run=0: EXAM high for 10 cycles, key_ack pulsed 3 cycles after key_valid rises.
  - key_valid rises one edge after the press with key_code=3, and falls at the ack edge.
  - EXAM re-pressed after only 5 low cycles gives no response.
  - EXAM re-pressed after 9 low cycles gives key_valid with code 3.
- run=1: press DEP → one-cycle key_reject, key_valid stays 0. After the release hold, press STOP → key_valid with key_code=5.
- run=0: START and LOAD ADD rise in the same cycle → exactly one request with key_code=0, and no key_reject.
- ACK_TIMEOUT=16, no ack: key_valid is high for exactly 16 cycles, then ack_timeout=1. ack_timeout stays 1 across later requests until rst.
- CONT held high while rst pulses for 2 cycles: no key_valid after reset. Release CONT for HOLD_CYCLES cycles and press again → key_valid with code 4.
- Toggle sing_step, then sing_inst, then both: outputs follow one cycle later, and key_valid is unaffected.

Source files
------------

// File: rtl/panel_key_sequencer.sv
// rtl/panel_key_sequencer.sv - front-panel key arbitration, interlock and request handshake
module panel_key_sequencer #(
  parameter int HOLD_CYCLES = 100000,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load_addr,
  input  logic       dep,
  input  logic       exam,
  input  logic       cont,
  input  logic       stop,
  input  logic       sing_step,
  input  logic       sing_inst,
  input  logic       run,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [2:0] key_code,
  output logic       key_reject,
  output logic       ack_timeout,
  output logic       sing_step_mode,
  output logic       sing_inst_mode
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RELEASE} state_t;

  localparam logic [23:0] HOLD_LIM = 24'(HOLD_CYCLES);
  localparam logic [23:0] TOUT_LIM = 24'(ACK_TIMEOUT);
  localparam logic [23:0] TMAX     = 24'hFF_FFFF;

  state_t      state, state_n;
  logic [5:0]  keys, prev, press;
  logic [2:0]  win;
  logic        any_press, accept;
  logic [23:0] timer, timer_n, timer_inc;
  logic        valid_n, reject_n, tout_n;
  logic [2:0]  code_n;

  // Bit index equals the key code, so the winner encodes directly.
  assign keys      = {stop, cont, exam, dep, load_addr, start};
  assign press     = keys & ~prev;
  assign any_press = |press;
  // STOP is the only key honoured while running, and the only one refused while halted.
  assign accept    = any_press && (run ? press[5] : !press[5]);
  assign timer_inc = (timer == TMAX) ? timer : timer + 24'd1;

  // Previous key levels track the inputs even in reset so a held key cannot fire on release.
  always_ff @(posedge clk) begin
    prev <= keys;
  end

  // Priority pick: STOP first, then lowest code wins.
  always_comb begin
    win = 3'd0;
    if (press[5])      win = 3'd5;
    else if (press[0]) win = 3'd0;
    else if (press[1]) win = 3'd1;
    else if (press[2]) win = 3'd2;
    else if (press[3]) win = 3'd3;
    else if (press[4]) win = 3'd4;
  end

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_n  = state;
    valid_n  = key_valid;
    code_n   = key_code;
    reject_n = 1'b0;
    tout_n   = ack_timeout;
    timer_n  = timer;
    case (state)
      IDLE: begin
        if (any_press) begin
          timer_n = 24'd0;
          if (accept) begin
            valid_n = 1'b1;
            code_n  = win;
            state_n = ISSUE;
          end else begin
            reject_n = 1'b1;
            state_n  = WAIT_RELEASE;
          end
        end
      end
      ISSUE: begin
        timer_n = timer_inc;
        if (key_ack) begin
          valid_n = 1'b0;
          timer_n = 24'd0;
          state_n = WAIT_RELEASE;
        end else if ((TOUT_LIM != 24'd0) && (timer_inc >= TOUT_LIM)) begin
          valid_n = 1'b0;
          tout_n  = 1'b1;
          timer_n = 24'd0;
          state_n = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (|keys) begin
          timer_n = 24'd0;
        end else begin
          timer_n = timer_inc;
          if (timer_inc >= HOLD_LIM) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_valid   <= 1'b0;
      key_code    <= 3'd0;
      key_reject  <= 1'b0;
      ack_timeout <= 1'b0;
      timer       <= 24'd0;
    end else begin
      state       <= state_n;
      key_valid   <= valid_n;
      key_code    <= code_n;
      key_reject  <= reject_n;
      ack_timeout <= tout_n;
      timer       <= timer_n;
    end
  end

  // Toggle switch levels are registered untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      sing_step_mode <= 1'b0;
      sing_inst_mode <= 1'b0;
    end else begin
      sing_step_mode <= sing_step;
      sing_inst_mode <= sing_inst;
    end
  end

endmodule

// File: tb/tb_panel_key_sequencer.sv
// tb/tb_panel_key_sequencer.sv - self-checking bench for panel_key_sequencer
module tb_panel_key_sequencer;

  localparam int HOLD = 8;
  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] keys = 6'd0;
  logic       sing_step = 1'b0, sing_inst = 1'b0, run = 1'b0, key_ack = 1'b0;
  logic       key_valid, key_reject, ack_timeout, sing_step_mode, sing_inst_mode;
  logic [2:0] key_code;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [5:0] m_prev;
  bit         m_ready, m_valid, m_reject, m_tout, m_ss, m_si;
  logic [2:0] m_code;
  int         m_age, m_quiet;

  panel_key_sequencer #(.HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .start(keys[0]), .load_addr(keys[1]), .dep(keys[2]),
    .exam(keys[3]), .cont(keys[4]), .stop(keys[5]),
    .sing_step(sing_step), .sing_inst(sing_inst), .run(run), .key_ack(key_ack),
    .key_valid(key_valid), .key_code(key_code), .key_reject(key_reject),
    .ack_timeout(ack_timeout), .sing_step_mode(sing_step_mode), .sing_inst_mode(sing_inst_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_out();
    return {key_valid, key_code, key_reject, ack_timeout, sing_step_mode, sing_inst_mode};
  endfunction

  function automatic logic [7:0] model_out();
    return {m_valid, m_code, m_reject, m_tout, m_ss, m_si};
  endfunction

  // One clock edge of the behaviour: ready / pending / cooling-down, with counters.
  task automatic model_step();
    logic [5:0] press;
    int w;
    bit ok;
    if (rst) begin
      m_prev = keys; m_ready = 1; m_valid = 0; m_code = 0; m_reject = 0;
      m_tout = 0; m_ss = 0; m_si = 0; m_age = 0; m_quiet = 0;
      return;
    end
    press = keys & ~m_prev;
    m_prev = keys;
    m_reject = 0;
    m_ss = sing_step;
    m_si = sing_inst;
    if (m_ready) begin
      if (press != 0) begin
        w = 0;
        for (int i = 4; i >= 0; i--) if (press[i]) w = i;
        if (press[5]) w = 5;
        ok = run ? (w == 5) : (w != 5);
        m_ready = 0;
        if (ok) begin
          m_valid = 1; m_code = 3'(w); m_age = 0;
        end else begin
          m_reject = 1; m_quiet = HOLD;
        end
      end
    end else if (m_valid) begin
      m_age++;
      if (key_ack) begin
        m_valid = 0; m_quiet = HOLD;
      end else if (m_age >= TOUT) begin
        m_valid = 0; m_tout = 1; m_quiet = HOLD;
      end
    end else begin
      if (keys != 0) m_quiet = HOLD;
      else m_quiet--;
      if (m_quiet <= 0) m_ready = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1; keys = 0;
    tick(); tick();
    vectors++;
    if (dut_out() !== 8'd0) begin
      miscompares++; $display("FAIL reset_state: got %b want %b", dut_out(), 8'd0);
    end
    rst = 0;
  endtask

  task automatic test_exam_ack();
    run = 0; keys[3] = 1;
    tick();
    vectors++;
    if ({key_valid, key_code} !== 4'b1_011) begin
      miscompares++; $display("FAIL exam_press: got %b want %b", {key_valid, key_code}, 4'b1_011);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++; $display("FAIL exam_hold: got %b want %b", dut_out(), model_out());
      end
    end
    key_ack = 1;
    tick();
    key_ack = 0;
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++; $display("FAIL exam_ack_drop: got %b want 0", key_valid);
    end
    settle(6);
    keys[3] = 0;
    settle(5);
    keys[3] = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({key_valid, key_reject} !== 2'b00) begin
        miscompares++; $display("FAIL exam_early_repress: got %b want 00", {key_valid, key_reject});
      end
    end
    keys[3] = 0;
    settle(9);
    keys[3] = 1;
    tick();
    vectors++;
    if ({key_valid, key_code} !== 4'b1_011) begin
      miscompares++; $display("FAIL exam_late_repress: got %b want %b", {key_valid, key_code}, 4'b1_011);
    end
    key_ack = 1; tick(); key_ack = 0; keys = 0;
    settle(HOLD + 1);
  endtask

  task automatic test_interlock();
    run = 1; keys[2] = 1;
    tick();
    vectors++;
    if ({key_valid, key_reject} !== 2'b01) begin
      miscompares++; $display("FAIL dep_reject: got %b want 01", {key_valid, key_reject});
    end
    tick();
    vectors++;
    if ({key_valid, key_reject} !== 2'b00) begin
      miscompares++; $display("FAIL reject_one_cycle: got %b want 00", {key_valid, key_reject});
    end
    keys = 0;
    settle(HOLD + 1);
    keys[5] = 1;
    tick();
    vectors++;
    if ({key_valid, key_code, key_reject} !== 5'b1_101_0) begin
      miscompares++; $display("FAIL stop_accept: got %b want %b", {key_valid, key_code, key_reject}, 5'b1_101_0);
    end
    key_ack = 1; tick(); key_ack = 0; keys = 0; run = 0;
    settle(HOLD + 1);
  endtask

  task automatic test_simultaneous();
    int reqs = 0;
    run = 0; keys[0] = 1; keys[1] = 1;
    tick();
    vectors++;
    if ({key_valid, key_code, key_reject} !== 5'b1_000_0) begin
      miscompares++; $display("FAIL start_wins: got %b want %b", {key_valid, key_code, key_reject}, 5'b1_000_0);
    end
    key_ack = 1; tick(); key_ack = 0;
    keys = 0;
    for (int i = 0; i < HOLD + 4; i++) begin
      tick();
      if (key_valid || key_reject) reqs++;
    end
    vectors++;
    if (reqs !== 0) begin
      miscompares++; $display("FAIL single_request: got %0d extra events want 0", reqs);
    end
  endtask

  task automatic test_toggles();
    logic [1:0] pat [4];
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      {sing_step, sing_inst} = pat[i];
      tick();
      vectors++;
      if ({sing_step_mode, sing_inst_mode, key_valid} !== {pat[i], 1'b0}) begin
        miscompares++; $display("FAIL toggle_%0d: got %b want %b", i, {sing_step_mode, sing_inst_mode, key_valid}, {pat[i], 1'b0});
      end
    end
  endtask

  task automatic test_timeout();
    int high = 0;
    run = 0; keys[4] = 1;
    vectors++;
    if (ack_timeout !== 1'b0) begin
      miscompares++; $display("FAIL timeout_pre: got %b want 0", ack_timeout);
    end
    for (int i = 0; i < TOUT + 6; i++) begin
      tick();
      if (key_valid) high++;
    end
    vectors++;
    if (high !== TOUT) begin
      miscompares++; $display("FAIL timeout_len: got %0d want %0d", high, TOUT);
    end
    vectors++;
    if (ack_timeout !== 1'b1) begin
      miscompares++; $display("FAIL timeout_flag: got %b want 1", ack_timeout);
    end
    keys = 0;
    settle(HOLD + 1);
    keys[0] = 1;
    tick();
    key_ack = 1; tick(); key_ack = 0; keys = 0;
    vectors++;
    if ({key_valid, ack_timeout} !== 2'b01) begin
      miscompares++; $display("FAIL timeout_sticky: got %b want 01", {key_valid, ack_timeout});
    end
    settle(HOLD + 1);
  endtask

  task automatic test_cont_reset();
    keys[4] = 1; rst = 1;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({key_valid, key_reject, ack_timeout} !== 3'b000) begin
        miscompares++; $display("FAIL held_through_reset: got %b want 000", {key_valid, key_reject, ack_timeout});
      end
    end
    keys[4] = 0;
    settle(HOLD);
    keys[4] = 1;
    tick();
    vectors++;
    if ({key_valid, key_code} !== 4'b1_100) begin
      miscompares++; $display("FAIL cont_after_reset: got %b want %b", {key_valid, key_code}, 4'b1_100);
    end
    key_ack = 1; tick(); key_ack = 0; keys = 0;
    settle(HOLD + 1);
  endtask

  task automatic test_random();
    int r;
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 15);
      if (r == 0) keys = 6'(1 << $urandom_range(0, 5));
      else if (r == 1) keys = 6'($urandom_range(0, 63));
      else if (r <= 4) keys = 6'd0;
      key_ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      sing_step = 1'($urandom_range(0, 1));
      sing_inst = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
      tick();
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        if (bad < 10) $display("FAIL random_cycle_%0d: got %b want %b", c, dut_out(), model_out());
        bad++;
      end
    end
    rst = 0; key_ack = 0; keys = 0;
  endtask

  initial begin
    test_reset();
    test_exam_ack();
    test_interlock();
    test_simultaneous();
    test_toggles();
    test_timeout();
    test_cont_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
